sinegen_sweep_ctrl: RTL
=======================

SINEGEN_SWEEP_CTRL -- requirements
Module: sinegen_sweep_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, width of incr/offset/step fields.
REQ-002 SHALL have parameter DW_WIDTH, default 16, width of dwell count.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  single-cycle request to begin a sweep.
REQ-006 stop  input  1  abort sweep; takes priority over start.
REQ-007 incr_lo  input  D_WIDTH  first increment value of sweep.
REQ-008 incr_hi  input  D_WIDTH  final increment value of sweep.
REQ-009 step  input  D_WIDTH  increment added per dwell period.
REQ-010 dwell  input  DW_WIDTH  cycles each increment value is held (0 treated as 1).
REQ-011 phase  input  8  second-channel phase offset.
REQ-012 sine_en  output  1  enable to downstream address counter.
REQ-013 incr  output  D_WIDTH  registered increment to address counter.
REQ-014 offset  output  8  registered phase offset to dual-port ROM.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at normal sweep completion.
REQ-017 err  output  1  one-cycle pulse on rejected start.

Function
REQ-018 States SHALL be IDLE, UP, DOWN (macro only), DONE; all outputs registered.
REQ-019 IDLE: sine_en=0, incr=0; offset holds last value.
REQ-020 start in IDLE with incr_lo<=incr_hi and step!=0 SHALL capture incr_lo, incr_hi, step, dwell, phase; next cycle incr=incr_lo, offset=phase, sine_en=1, state UP.
REQ-021 start in IDLE with incr_lo>incr_hi or step==0 SHALL pulse err next cycle, stay IDLE.
REQ-022 Inputs other than start/stop SHALL be ignored outside the capture cycle; start while busy SHALL be ignored.
REQ-023 Each incr value SHALL be held exactly max(dwell,1) cycles via down-counter reloaded on every incr change.
REQ-024 UP, dwell expiry, incr<incr_hi: incr <= min(incr+step, incr_hi), computed at D_WIDTH+1 bits (no wrap).
REQ-025 UP, dwell expiry, incr==incr_hi: go DONE (or DOWN per REQ-033).
REQ-026 DONE: one cycle, done=1, sine_en=0, incr=0 next; then IDLE.
REQ-027 stop in UP/DOWN SHALL go IDLE next cycle, sine_en=0, incr=0, no done pulse.
REQ-028 stop and start same cycle in IDLE: start ignored, no err.
REQ-029 incr_lo==incr_hi SHALL produce one dwell period at that value, then DONE.

Reset
REQ-030 rst low SHALL immediately force IDLE, sine_en=0, incr=0, offset=0, busy=0, done=0, err=0, dwell counter=0.
REQ-031 Reset mid-sweep SHALL discard captured config; no done pulse after release.
REQ-032 First start SHALL be honoured on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro SINEGEN_SWEEP_DOWN_EN defined: at incr==incr_hi expiry go DOWN; DOWN steps incr <= max(incr-step, incr_lo) per dwell; expiry at incr==incr_lo goes DONE; incr_hi held one dwell only (not repeated).
REQ-034 Macro undefined: DOWN state absent; UP ends directly in DONE.

Verification
REQ-035 rst low mid-UP with incr=0x20 -> all outputs 0 asynchronously, IDLE after release, no done.
REQ-036 lo=0x10, hi=0x20, step=0x08, dwell=3 -> incr 0x10,0x18,0x20 each 3 cycles, then done pulse, sine_en low (macro off).
REQ-037 Same with SINEGEN_SWEEP_DOWN_EN -> 0x10,0x18,0x20,0x18,0x10 each 3 cycles, then done.
REQ-038 lo=0xF0, hi=0xFF, step=0x20, dwell=0 -> 0xF0 one cycle, 0xFF one cycle (saturate, no wrap), done.
REQ-039 start with step=0, then lo=0x30/hi=0x10 -> err pulse each, busy stays 0.
REQ-040 stop asserted 5 cycles into sweep, start during sweep -> start ignored, IDLE next cycle after stop, done never pulses.

Source files
------------

// File: rtl/sinegen_sweep_ctrl_if.sv
// Request/status bundle between a sweep host and sinegen_sweep_ctrl.
// The host (master) drives sweep configuration; the controller (slave) returns the NCO controls.
interface sinegen_sweep_ctrl_if #(
  parameter int D_WIDTH  = 8,
  parameter int DW_WIDTH = 16
);
  logic                start;
  logic                stop;
  logic [D_WIDTH-1:0]  incr_lo;
  logic [D_WIDTH-1:0]  incr_hi;
  logic [D_WIDTH-1:0]  step;
  logic [DW_WIDTH-1:0] dwell;
  logic [7:0]          phase;
  logic                sine_en;
  logic [D_WIDTH-1:0]  incr;
  logic [7:0]          offset;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, stop, incr_lo, incr_hi, step, dwell, phase,
    input  sine_en, incr, offset, busy, done, err
  );

  modport slave (
    input  start, stop, incr_lo, incr_hi, step, dwell, phase,
    output sine_en, incr, offset, busy, done, err
  );
endinterface

// File: rtl/sinegen_sweep_ctrl.sv
// Frequency-sweep controller for a sine NCO: steps the phase increment from incr_lo to incr_hi.
// Define SINEGEN_SWEEP_DOWN_EN to add a return sweep from incr_hi back down to incr_lo.
module sinegen_sweep_ctrl #(
  parameter int D_WIDTH  = 8,
  parameter int DW_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  sinegen_sweep_ctrl_if.slave bus
);

`ifdef SINEGEN_SWEEP_DOWN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DONE = 2'd3} state_e;
`endif

  localparam logic [DW_WIDTH-1:0] DW_ONE = {{(DW_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [D_WIDTH-1:0]  incr_q, incr_d;
  logic [7:0]          offset_q, offset_d;
  logic                sine_en_q, sine_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [D_WIDTH-1:0]  hi_q, hi_d;
  logic [D_WIDTH-1:0]  step_q, step_d;
  logic [DW_WIDTH-1:0] dwell_q, dwell_d;
  logic [DW_WIDTH-1:0] cnt_q, cnt_d;
  logic [D_WIDTH:0]    sum_s;
  logic [D_WIDTH-1:0]  up_sat_s;
  logic [DW_WIDTH-1:0] reload_s;
  logic                cfg_ok_s;
`ifdef SINEGEN_SWEEP_DOWN_EN
  logic [D_WIDTH-1:0]  lo_q, lo_d;
  logic [D_WIDTH:0]    diff_s;
  logic [D_WIDTH-1:0]  dn_sat_s;
`endif

  // Saturating step arithmetic is done one bit wider so the increment never wraps.
  always_comb begin
    sum_s    = {1'b0, incr_q} + {1'b0, step_q};
    reload_s = (dwell_q == {DW_WIDTH{1'b0}}) ? {DW_WIDTH{1'b0}} : dwell_q - DW_ONE;
    cfg_ok_s = (bus.incr_lo <= bus.incr_hi) && (bus.step != {D_WIDTH{1'b0}});
    if (sum_s > {1'b0, hi_q}) begin
      up_sat_s = hi_q;
    end else begin
      up_sat_s = sum_s[D_WIDTH-1:0];
    end
`ifdef SINEGEN_SWEEP_DOWN_EN
    diff_s = {1'b0, incr_q} - {1'b0, step_q};
    if (diff_s[D_WIDTH] || (diff_s[D_WIDTH-1:0] < lo_q)) begin
      dn_sat_s = lo_q;
    end else begin
      dn_sat_s = diff_s[D_WIDTH-1:0];
    end
`endif
  end

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    incr_d    = incr_q;
    offset_d  = offset_q;
    sine_en_d = sine_en_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    hi_d      = hi_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
`ifdef SINEGEN_SWEEP_DOWN_EN
    lo_d      = lo_q;
`endif
    case (state_q)
      IDLE: begin
        incr_d    = {D_WIDTH{1'b0}};
        sine_en_d = 1'b0;
        cnt_d     = {DW_WIDTH{1'b0}};
        if (bus.start && !bus.stop) begin
          if (cfg_ok_s) begin
            state_d   = UP;
            incr_d    = bus.incr_lo;
            offset_d  = bus.phase;
            sine_en_d = 1'b1;
            hi_d      = bus.incr_hi;
            step_d    = bus.step;
            dwell_d   = bus.dwell;
            cnt_d     = (bus.dwell == {DW_WIDTH{1'b0}}) ? {DW_WIDTH{1'b0}} : bus.dwell - DW_ONE;
`ifdef SINEGEN_SWEEP_DOWN_EN
            lo_d      = bus.incr_lo;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      UP: begin
        if (bus.stop) begin
          state_d   = IDLE;
          incr_d    = {D_WIDTH{1'b0}};
          sine_en_d = 1'b0;
        end else if (cnt_q != {DW_WIDTH{1'b0}}) begin
          cnt_d = cnt_q - DW_ONE;
        end else if (incr_q != hi_q) begin
          incr_d = up_sat_s;
          cnt_d  = reload_s;
`ifdef SINEGEN_SWEEP_DOWN_EN
        end else if (hi_q != lo_q) begin
          // Top value already had its dwell; enter the return leg one step down.
          state_d = DOWN;
          incr_d  = dn_sat_s;
          cnt_d   = reload_s;
`endif
        end else begin
          state_d   = DONE;
          incr_d    = {D_WIDTH{1'b0}};
          sine_en_d = 1'b0;
          done_d    = 1'b1;
        end
      end
`ifdef SINEGEN_SWEEP_DOWN_EN
      DOWN: begin
        if (bus.stop) begin
          state_d   = IDLE;
          incr_d    = {D_WIDTH{1'b0}};
          sine_en_d = 1'b0;
        end else if (cnt_q != {DW_WIDTH{1'b0}}) begin
          cnt_d = cnt_q - DW_ONE;
        end else if (incr_q != lo_q) begin
          incr_d = dn_sat_s;
          cnt_d  = reload_s;
        end else begin
          state_d   = DONE;
          incr_d    = {D_WIDTH{1'b0}};
          sine_en_d = 1'b0;
          done_d    = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d   = IDLE;
        incr_d    = {D_WIDTH{1'b0}};
        sine_en_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        incr_d    = {D_WIDTH{1'b0}};
        sine_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything including the captured sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      incr_q    <= {D_WIDTH{1'b0}};
      offset_q  <= 8'h00;
      sine_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hi_q      <= {D_WIDTH{1'b0}};
      step_q    <= {D_WIDTH{1'b0}};
      dwell_q   <= {DW_WIDTH{1'b0}};
      cnt_q     <= {DW_WIDTH{1'b0}};
`ifdef SINEGEN_SWEEP_DOWN_EN
      lo_q      <= {D_WIDTH{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      incr_q    <= incr_d;
      offset_q  <= offset_d;
      sine_en_q <= sine_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
`ifdef SINEGEN_SWEEP_DOWN_EN
      lo_q      <= lo_d;
`endif
    end
  end

  assign bus.sine_en = sine_en_q;
  assign bus.incr    = incr_q;
  assign bus.offset  = offset_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
